// File: rtl/bram_responder.sv
// bram_responder: valid/ready request front-end for a single-port,
// read-first block RAM with a fixed 1-cycle read latency. Every accepted
// request (read or write) produces exactly one in-order response carrying
// the word's contents as they were before the request's write. A 3-entry
// response FIFO keeps full throughput under backpressure while req_ready
// depends on registers (and rst) only, never on resp_ready.
module bram_responder #(
    parameter int abits  = 8,
    parameter int dbytes = 4,
    parameter int blen   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [abits-1:0]         req_addr,
    input  logic [dbytes-1:0]        req_we,
    input  logic [dbytes*blen-1:0]   req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [dbytes*blen-1:0]   resp_rdata,
    output logic [dbytes-1:0]        ram_we,
    output logic [abits-1:0]         ram_addr,
    output logic [dbytes*blen-1:0]   ram_wdata,
    input  logic [dbytes*blen-1:0]   ram_rdata
);

    localparam int dbits = dbytes * blen;

    // S1 marks the cycle in which the RAM output carries an accepted request's data.
    logic             s1_valid;

    // Response FIFO state: 3 slots, pointers wrap 2 -> 0.
    logic [dbits-1:0] fifo [0:2];
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;
    logic [1:0]       count;

    logic             acc;
    logic             push;
    logic             pop;
    logic [2:0]       outstanding;

    // Pointer increment with wrap after the last of the three slots.
    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Every request in S1 or in the FIFO already owns a FIFO slot, so
    // accepting only while fewer than 3 are outstanding makes overflow impossible.
    assign outstanding = {2'b00, s1_valid} + {1'b0, count};
    assign req_ready   = !rst && (outstanding < 3'd3);
    assign acc         = req_valid && req_ready;

    // RAM is driven straight from the request; only an accepted request writes.
    assign ram_addr    = req_addr;
    assign ram_wdata   = req_wdata;
    assign ram_we      = acc ? req_we : '0;

    // Responses are hidden during reset so nothing buffered is ever presented.
    assign resp_valid  = !rst && (count != 2'd0);
    assign resp_rdata  = fifo[rd_ptr];
    assign push        = s1_valid;
    assign pop         = resp_valid && resp_ready;

    // Track which cycle carries valid RAM read data for an accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= acc;
        end
    end

    // FIFO pointer and occupancy bookkeeping; push and pop together keep count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Capture the RAM read data into the FIFO slot at the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_bram_responder.sv
// Testbench for bram_responder: a behavioural read-first RAM sits on the
// RAM ports, and a reference model (golden memory plus a queue of expected
// responses with the cycle each one may first appear) checks every cycle.
module tb_bram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_addr = 8'h00;
    logic [3:0]  req_we = 4'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic [3:0]  ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic        preload_en = 1'b0;
    logic [7:0]  preload_addr = 8'h00;
    logic [31:0] preload_data = 32'h0;

    typedef struct {
        logic [31:0] data;
        int          ready_at;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] got_q [$];
    logic [31:0] ram_mem [256];
    logic [31:0] gold [256];

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int last_pop_cyc = 0;
    int acc_cyc = 0;
    int stalls = 0;

    bram_responder #(.abits(8), .dbytes(4), .blen(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_we     (req_we),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] preload_val(input logic [7:0] a);
        if (a == 8'h05) return 32'hDEADBEEF;
        if (a == 8'h10) return 32'h11223344;
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Behavioural read-first RAM with 1-cycle latency, plus a backdoor preload path.
    always @(posedge clk) begin
        if (preload_en) begin
            ram_mem[preload_addr] <= preload_data;
        end else begin
            ram_rdata <= ram_mem[ram_addr];
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    // Reference model: checks outputs mid-cycle, then advances the model across the next edge.
    always @(negedge clk) begin
        bit acc;
        bit pop;
        bit exp_valid;
        cyc++;
        if (preload_en) gold[preload_addr] = preload_data;
        exp_valid = !rst && exp_q.size() > 0 && exp_q[0].ready_at <= cyc;
        acc = req_valid && !rst && exp_q.size() < 3;
        checkOutput("req_ready", req_ready, !rst && exp_q.size() < 3);
        checkOutput("resp_valid", resp_valid, exp_valid);
        if (exp_valid) checkOutput("resp_rdata", resp_rdata, exp_q[0].data);
        checkOutput("ram_we", ram_we, acc ? req_we : 4'h0);
        if (resp_valid && resp_ready) begin
            got_q.push_back(resp_rdata);
            last_pop_cyc = cyc;
        end
        pop = exp_valid && resp_ready;
        if (pop) begin
            void'(exp_q.pop_front());
            if (exp_q.size() > 0 && exp_q[0].ready_at < cyc + 1) exp_q[0].ready_at = cyc + 1;
        end
        if (acc) begin
            exp_q.push_back('{data: gold[req_addr], ready_at: cyc + 2});
            for (int b = 0; b < 4; b++) begin
                if (req_we[b]) gold[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
            end
        end
        if (rst) exp_q.delete();
    end

    // Drive one cycle of inputs and move to just after the next rising edge.
    task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [3:0] w,
                                 input logic [31:0] d, input logic rr, input logic rs);
        req_valid = v; req_addr = a; req_we = w; req_wdata = d;
        resp_ready = rr; rst = rs;
        @(posedge clk); #1;
    endtask

    // Offer one request and hold it until it is accepted (bounded).
    task automatic sendReq(input logic [7:0] a, input logic [3:0] w, input logic [31:0] d);
        bit accepted;
        int waits;
        req_valid = 1'b1; req_addr = a; req_we = w; req_wdata = d;
        accepted = 0;
        waits = 0;
        while (!accepted && waits < 50) begin
            @(negedge clk);
            accepted = req_ready;
            @(posedge clk); #1;
            if (!accepted) waits++;
        end
        stalls += waits;
        acc_cyc = cyc;
        if (!accepted) checkOutput("req_timeout", 0, 1);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we = 4'h0;
    endtask

    task automatic drainAll();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        checkOutput("drain", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        bit acc;

        // Preload every RAM word while reset is held.
        @(posedge clk); #1;
        preload_en = 1'b1;
        for (int a = 0; a < 256; a++) begin
            preload_addr = 8'(a);
            preload_data = preload_val(8'(a));
            @(posedge clk); #1;
        end
        preload_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Single read with exact latency.
        sendReq(8'h05, 4'h0, 32'h0);
        idle();
        @(negedge clk); checkOutput("rd_lat1", resp_valid, 0);
        @(negedge clk); checkOutput("rd_lat2", resp_valid, 1);
        checkOutput("rd_data", resp_rdata, 32'hDEADBEEF);
        @(negedge clk); checkOutput("rd_once", resp_valid, 0);
        @(posedge clk); #1;

        // Partial write then immediate read of the same word.
        got_q.delete();
        sendReq(8'h10, 4'b0011, 32'hAABBCCDD);
        sendReq(8'h10, 4'h0, 32'h0);
        idle();
        drainAll();
        checkOutput("wr_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            checkOutput("wr_old", got_q[0], 32'h11223344);
            checkOutput("rd_new", got_q[1], 32'h1122CCDD);
        end

        // Streaming reads 0x00..0x0F.
        got_q.delete();
        stalls = 0;
        for (int i = 0; i < 16; i++) sendReq(8'(i), 4'h0, 32'h0);
        idle();
        drainAll();
        checkOutput("stream_stalls", stalls, 0);
        checkOutput("stream_count", got_q.size(), 16);
        for (int i = 0; i < got_q.size() && i < 16; i++)
            checkOutput("stream_data", got_q[i], preload_val(8'(i)));
        checkOutput("stream_last_lat", last_pop_cyc - acc_cyc, 2);

        // Backpressure: only 3 accepted while resp_ready is low.
        got_q.delete();
        resp_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            req_valid = 1'b1; req_addr = 8'(32'h20 + n); req_we = 4'h0;
            @(negedge clk);
            acc = req_ready;
            @(posedge clk); #1;
            if (acc) n++;
        end
        checkOutput("bp_accepted", n, 3);
        @(negedge clk);
        checkOutput("bp_ready_low", req_ready, 0);
        checkOutput("bp_hold_valid", resp_valid, 1);
        checkOutput("bp_hold_data", resp_rdata, preload_val(8'h20));
        @(posedge clk); #1;
        resp_ready = 1'b1;
        while (n < 8) begin
            sendReq(8'(32'h20 + n), 4'h0, 32'h0);
            n++;
        end
        idle();
        drainAll();
        checkOutput("bp_count", got_q.size(), 8);
        for (int i = 0; i < got_q.size() && i < 8; i++)
            checkOutput("bp_data", got_q[i], preload_val(8'(32'h20 + i)));

        // Reset with 3 outstanding requests.
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) sendReq(8'(32'h40 + i), 4'h0, 32'h0);
        idle();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_req_ready", req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        resp_ready = 1'b1;
        got_q.delete();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("rst_no_stale", got_q.size(), 0);
        sendReq(8'h05, 4'h0, 32'h0);
        idle();
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_fresh_valid", resp_valid, 1);
        checkOutput("rst_fresh_data", resp_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        got_q.delete();
        sendReq(8'h10, 4'h0, 32'h0);
        idle();
        drainAll();
        checkOutput("rst_ram_kept", got_q.size() > 0 ? got_q[0] : 32'h0, 32'h1122CCDD);

        // Idle write guard: not valid, then valid while not ready.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h30, 4'hF, 32'h0, 1'b1, 1'b0);
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) sendReq(8'(32'h50 + i), 4'h0, 32'h0);
        req_valid = 1'b1; req_addr = 8'h31; req_we = 4'hF; req_wdata = 32'h0;
        @(negedge clk);
        checkOutput("guard_ready", req_ready, 0);
        checkOutput("guard_we", ram_we, 4'h0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        idle();
        resp_ready = 1'b1;
        drainAll();
        got_q.delete();
        sendReq(8'h30, 4'h0, 32'h0);
        sendReq(8'h31, 4'h0, 32'h0);
        idle();
        drainAll();
        checkOutput("guard_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            checkOutput("guard_30", got_q[0], preload_val(8'h30));
            checkOutput("guard_31", got_q[1], preload_val(8'h31));
        end

        // Randomized traffic with hazards, backpressure and occasional reset.
        for (int i = 0; i < 500; i++) begin
            applyStimulus(($urandom % 4) != 0, 8'($urandom % 16),
                          ($urandom % 2) ? 4'($urandom % 16) : 4'h0, $urandom,
                          ($urandom % 4) != 0, ($urandom % 64) == 0);
        end
        applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 1'b0);
        drainAll();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
